// File: rtl/brisc_pkg.sv
// ------------------------------------------------------------------
// brisc_pkg : shared register-file widths and writeback stage types
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package brisc_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ------------------------------------------------------------------
// wb_fifo : synchronous {addr, data} FIFO exposing per-slot occupancy
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full      = (r_count == (PTR_W+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign head_addr = r_addr_mem[r_rd_ptr];
  assign head_data = r_data_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_addr_mem[r_wr_ptr] <= push_addr;
      r_data_mem[r_wr_ptr] <= push_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic [PTR_W-1:0] c_slot = PTR_W'(i);
    logic [PTR_W-1:0] w_offset;
    assign w_offset       = c_slot - r_rd_ptr;
    assign entry_valid[i] = ({1'b0, w_offset} < r_count);
    assign entry_addr[i]  = r_addr_mem[i];
  end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ------------------------------------------------------------------
// writeback_stage : arbitrates ALU/load results into a FIFO and drives a
// setup-safe register-file write strobe plus a RAW pending bitmap
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module writeback_stage #(
  parameter int DATA_W = brisc_pkg::DATA_W,
  parameter int ADDR_W = brisc_pkg::REG_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [ADDR_W-1:0]     alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  output logic [ADDR_W-1:0]     write_addr,
  output logic [DATA_W-1:0]     write_data,
  output logic                  write_enable,
  output logic [2**ADDR_W-1:0]  pending,
  output logic                  idle
);

  import brisc_pkg::*;

  wb_state_t                   r_state;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic [ADDR_W-1:0]           w_push_addr;
  logic [DATA_W-1:0]           w_push_data;
  logic [ADDR_W-1:0]           w_head_addr;
  logic [DATA_W-1:0]           w_head_data;
  logic [DEPTH-1:0]            w_entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] w_entry_addr;

  // Loads win arbitration; the ALU only sees ready when no load is offered.
  assign mem_ready   = !w_full;
  assign alu_ready   = !w_full && !mem_valid;
  assign w_push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign w_push_addr = mem_valid ? mem_addr : alu_addr;
  assign w_push_data = mem_valid ? mem_data : alu_data;
  assign w_pop       = !w_empty && ((r_state == IDLE) || (r_state == STROBE));
  assign idle        = w_empty && (r_state == IDLE);

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (w_push),
    .push_addr   (w_push_addr),
    .push_data   (w_push_data),
    .pop         (w_pop),
    .full        (w_full),
    .empty       (w_empty),
    .head_addr   (w_head_addr),
    .head_data   (w_head_data),
    .entry_valid (w_entry_valid),
    .entry_addr  (w_entry_addr)
  );

  // SETUP holds addr/data for a full cycle before the one-cycle strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      write_addr   <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            write_addr <= w_head_addr;
            write_data <= w_head_data;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          write_enable <= 1'b1;
          r_state      <= STROBE;
        end
        STROBE: begin
          if (!w_empty) begin
            write_addr <= w_head_addr;
            write_data <= w_head_data;
            r_state    <= SETUP;
          end else begin
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i]) pending[w_entry_addr[i]] = 1'b1;
    end
    if (r_state != IDLE) pending[write_addr] = 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ------------------------------------------------------------------
// tb_writeback_stage : directed self-checking bench with a register-file model
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic [3:0]  write_addr;
  logic [15:0] write_data;
  logic        write_enable;
  logic [15:0] pending;
  logic        idle;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [15:0] rf [16] = '{default: 16'h0000};
  logic [3:0]  log_addr [$];
  logic [15:0] log_data [$];
  int          log_cyc  [$];

  writeback_stage #(
    .DATA_W (16),
    .ADDR_W (4),
    .DEPTH  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .pending      (pending),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: captures on the rising edge of the strobe.
  always @(posedge write_enable) begin
    rf[write_addr] = write_data;
    log_addr.push_back(write_addr);
    log_data.push_back(write_data);
    log_cyc.push_back(cyc);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (idle === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
    tick(); tick();
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", write_enable); end
    checks++; if (write_addr !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", write_addr); end
    checks++; if (write_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0000", write_data); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0000", pending); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got alu=%b mem=%b expected 1 1", alu_ready, mem_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write;
    bit ok;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle_timeout: got busy expected idle"); end
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready: got %b expected 1", alu_ready); end
    tick();                                  // edge T: accepted
    alu_valid = 1'b0;
    checks++; if (pending[3] !== 1'b1 || write_enable !== 1'b0) begin
      errors++; $display("FAIL single_T_pending: got pend3=%b we=%b expected 1 0", pending[3], write_enable);
    end
    tick();                                  // T+1: SETUP
    checks++; if (write_enable !== 1'b0 || write_addr !== 4'd3 || write_data !== 16'h1234) begin
      errors++; $display("FAIL single_setup: got we=%b addr=%h data=%h expected 0 3 1234", write_enable, write_addr, write_data);
    end
    tick();                                  // T+2: STROBE
    checks++; if (write_enable !== 1'b1 || write_addr !== 4'd3 || write_data !== 16'h1234 || pending[3] !== 1'b1) begin
      errors++; $display("FAIL single_strobe: got we=%b addr=%h data=%h pend3=%b expected 1 3 1234 1",
                         write_enable, write_addr, write_data, pending[3]);
    end
    tick();                                  // T+3: back to IDLE
    checks++; if (write_enable !== 1'b0 || pending !== 16'h0 || idle !== 1'b1) begin
      errors++; $display("FAIL single_retire: got we=%b pend=%h idle=%b expected 0 0000 1", write_enable, pending, idle);
    end
    checks++; if (rf[3] !== 16'h1234) begin errors++; $display("FAIL single_rf: got %h expected 1234", rf[3]); end
  endtask

  task automatic test_simultaneous;
    bit ok;
    wait_idle(ok);
    clear_log();
    mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 16'h5555;
    #1;
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      errors++; $display("FAIL simul_arb: got mem_ready=%b alu_ready=%b expected 1 0", mem_ready, alu_ready);
    end
    tick();
    mem_valid = 1'b0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL simul_alu_next: got %b expected 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    for (int k = 0; k < 30 && log_addr.size() < 2; k++) tick();
    checks++; if (log_addr.size() != 2) begin
      errors++; $display("FAIL simul_count: got %0d strobes expected 2", log_addr.size());
    end else begin
      checks++; if (log_addr[0] !== 4'd5 || log_data[0] !== 16'hAAAA) begin
        errors++; $display("FAIL simul_first: got r%0d=%h expected r5=aaaa", log_addr[0], log_data[0]);
      end
      checks++; if (log_addr[1] !== 4'd6 || log_data[1] !== 16'h5555) begin
        errors++; $display("FAIL simul_second: got r%0d=%h expected r6=5555", log_addr[1], log_data[1]);
      end
      checks++; if (log_cyc[1] - log_cyc[0] != 2) begin
        errors++; $display("FAIL simul_spacing: got %0d cycles expected 2", log_cyc[1] - log_cyc[0]);
      end
    end
  endtask

  task automatic test_full;
    bit ok;
    int stalls;
    int tries;
    wait_idle(ok);
    clear_log();
    stalls = 0;
    mem_valid = 1'b0;
    // Eight back-to-back writes: the FIFO fills once (after the seventh push).
    for (int i = 1; i <= 8; i++) begin
      alu_valid = 1'b1; alu_addr = 4'(i); alu_data = 16'h0100 + 16'(i);
      #1;
      tries = 0;
      while (alu_ready !== 1'b1 && tries < 10) begin
        stalls++;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL full_mem_ready: got %b expected 0", mem_ready); end
        tick();
        tries++;
      end
      tick();
    end
    alu_valid = 1'b0;
    checks++; if (stalls != 1) begin errors++; $display("FAIL full_stalls: got %0d expected 1", stalls); end
    for (int k = 0; k < 60 && log_addr.size() < 8; k++) tick();
    checks++; if (log_addr.size() != 8) begin
      errors++; $display("FAIL full_count: got %0d strobes expected 8", log_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (log_addr[i] !== 4'(i + 1) || log_data[i] !== 16'h0101 + 16'(i)) begin
          errors++; $display("FAIL full_order[%0d]: got r%0d=%h expected r%0d=%h",
                             i, log_addr[i], log_data[i], i + 1, 16'h0101 + 16'(i));
        end
      end
      checks++; if (log_cyc[7] - log_cyc[0] != 14) begin
        errors++; $display("FAIL full_throughput: got %0d cycles expected 14", log_cyc[7] - log_cyc[0]);
      end
    end
  endtask

  task automatic test_duplicate;
    bit ok;
    int lows;
    wait_idle(ok);
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 16'h0001;
    tick();
    alu_data = 16'h0002;
    tick();
    alu_valid = 1'b0;
    lows = 0;
    for (int k = 0; k < 4; k++) begin
      if (pending[2] !== 1'b1) lows++;
      if (k < 3) tick();
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL dup_pending_held: got %0d low samples expected 0", lows); end
    checks++; if (write_enable !== 1'b1 || write_addr !== 4'd2 || write_data !== 16'h0002) begin
      errors++; $display("FAIL dup_second_strobe: got we=%b addr=%h data=%h expected 1 2 0002", write_enable, write_addr, write_data);
    end
    tick();
    checks++; if (pending[2] !== 1'b0) begin errors++; $display("FAIL dup_pending_clear: got %b expected 0", pending[2]); end
    checks++; if (rf[2] !== 16'h0002) begin errors++; $display("FAIL dup_rf: got %h expected 0002", rf[2]); end
  endtask

  task automatic test_reset_in_setup;
    bit ok;
    int n_before;
    logic [15:0] r7_before;
    wait_idle(ok);
    r7_before = rf[7];
    mem_valid = 1'b0;
    alu_valid = 1'b1;
    alu_addr = 4'd1; alu_data = 16'h0011; tick();
    alu_addr = 4'd7; alu_data = 16'h0077; tick();
    alu_addr = 4'd8; alu_data = 16'h0088; tick();
    alu_addr = 4'd9; alu_data = 16'h0099; tick();
    alu_valid = 1'b0;
    // r7 now in SETUP with r8 and r9 queued.
    checks++; if (write_addr !== 4'd7 || write_enable !== 1'b0 || pending[9:7] !== 3'b111) begin
      errors++; $display("FAIL rst_setup_pre: got addr=%h we=%b pend=%h expected 7 0 with r7..r9 set",
                         write_addr, write_enable, pending);
    end
    n_before = log_addr.size();
    reset = 1'b1;
    tick();
    checks++; if (write_enable !== 1'b0 || pending !== 16'h0 || idle !== 1'b1) begin
      errors++; $display("FAIL rst_setup_state: got we=%b pend=%h idle=%b expected 0 0000 1", write_enable, pending, idle);
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    checks++; if (log_addr.size() != n_before) begin
      errors++; $display("FAIL rst_setup_nostrobe: got %0d strobes expected %0d", log_addr.size(), n_before);
    end
    checks++; if (rf[7] !== r7_before) begin errors++; $display("FAIL rst_setup_r7: got %h expected %h", rf[7], r7_before); end
    checks++; if (pending !== 16'h0 || idle !== 1'b1) begin
      errors++; $display("FAIL rst_setup_after: got pend=%h idle=%b expected 0000 1", pending, idle);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_full();
    test_duplicate();
    test_reset_in_setup();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
